jtag_host_driver: RTL and testbench
===================================

// Module: jtag_host_driver
// PURPOSE
//  JTAG initiator (probe side) that drives tck/tms/tdi and samples tdo of the team's TAP (jtag_test_logic).
//  It sits in the sys_clk domain of a test harness or on-chip debug master.
//  It executes word-level commands (TAP reset, idle clocks, IR scan, DR scan) and returns the captured tdo bits.
// PARAMETERS
//  CLK_DIV  4   sys_clk cycles per tck half-period; legal range >=1
//  MAX_LEN  32  maximum scan length in bits; also the width of cmd_data and rsp_data
// PORTS
//  sys_clk    in   1                      system clock; the only clock in this block
//  sys_rst_n  in   1                      asynchronous, active-low reset
//  cmd_valid  in   1                      command offered
//  cmd_ready  out  1                      command accepted when cmd_valid && cmd_ready
//  cmd_op     in   2                      op_e: RESET=0, IDLE=1, SHIFT_IR=2, SHIFT_DR=3
//  cmd_len    in   $clog2(MAX_LEN+1)      scan bits (SHIFT_*) or tck count (IDLE)
//  cmd_data   in   MAX_LEN                tdi bits, LSB shifted first
//  rsp_valid  out  1                      response valid; held until rsp_ready
//  rsp_ready  in   1                      response consumed
//  rsp_data   out  MAX_LEN                captured tdo bits, right-aligned: first bit at bit 0, zero-filled above
//  rsp_err    out  1                      command rejected; no tck edges were issued
//  busy       out  1                      a command is in progress
//  tck, tms, tdi  out  1                  JTAG drive signals
//  tdo        in   1                      JTAG return signal, already synchronous to sys_clk in this environment
// BEHAVIOUR
//  Reset values: tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, tap_known=0.
//  tck period is 2*CLK_DIV sys_clk cycles: low phase, then high phase. tck idles low.
//  tms/tdi change only in the cycle where tck falls, or at command start while tck is low.
//  tdo is sampled in the sys_clk cycle in which tck rises.
//  Acceptance: cmd_ready = (state==IDLE) && !rsp_valid. The cycle after acceptance, busy=1 and the first low phase begins.
//  FSM: IDLE -> PRE (entry tms bits) -> SCAN -> POST (exit tms bits) -> RSP -> IDLE.
//   RESET:    tms 1,1,1,1,1,0 (6 tck). Sets tap_known=1; TAP ends in Run-Test/Idle.
//   IDLE:     cmd_len tck with tms=0.
//   SHIFT_DR: tms 1,0,0; then cmd_len bits with tms=0 except the last bit, which has tms=1; then tms 1,0. Total len+5 tck.
//   SHIFT_IR: tms 1,1,0,0; then the same scan and exit as SHIFT_DR. Total len+6 tck.
//   Sampled tdo shifts in at bit MAX_LEN-1 and the register shifts right.
//   At end, rsp_data = reg >> (MAX_LEN-len). tdi is 0 outside SCAN.
//  rsp_valid rises the cycle after the final tck falling edge. It holds with rsp_data and rsp_err stable until rsp_ready.
//   rsp_valid clears the cycle after the rsp_valid && rsp_ready handshake.
//  Errors (rsp_valid the cycle after acceptance, rsp_err=1, rsp_data=0, tck stays low, tap_known unchanged):
//   - SHIFT_IR/SHIFT_DR with len==0
//   - any cmd_len > MAX_LEN
//   - SHIFT_* or IDLE while tap_known==0
//  IDLE with len==0 and tap_known==1 returns rsp_err=0 without issuing any tck.
//  sys_rst_n asserted mid-command: all outputs take reset values immediately; the command is lost; tap_known=0.
//  cmd_valid while busy is ignored; cmd_* is captured only at the handshake.
// CONFIGURATION
//  JTAG_HOST_TRST_EN defined:
//   - adds output trst (active-low). Reset value is 0.
//   - RESET drives trst=0 for the first 5 tck and trst=1 from the 6th tck on.
//   - trst stays 1 thereafter until sys_rst_n.
//  JTAG_HOST_TRST_EN undefined: no trst port; RESET uses tms sequencing only.
// STRUCTURE
//  jtag_host_pkg: op_e, host state enum, entry/exit tms constants, and pre/post lengths for DR and IR.
//  Sub-module jtag_host_tck_gen (CLK_DIV counter) outputs:
//   - tck
//   - fall_stb and rise_stb, single-cycle strobes
//   - run input; the generator stops with tck low.
//  The top level holds the FSM, bit counter and shift register.
// TESTING
//  Reset release, then SHIFT_DR len=8 -> rsp_valid, rsp_err=1, rsp_data=0, zero tck rising edges.
//  RESET -> exactly 6 tck rises with tms 1,1,1,1,1,0; rsp_err=0; the TAP model reports Run-Test/Idle.
//  SHIFT_IR len=4 data=4'b0001 against a TAP model with IR capture 4'b0101:
//   - 10 tck, tms 1,1,0,0,0,0,0,1,1,0
//   - tdi 1,0,0,0 during scan
//   - rsp_data=32'h5
//  After IDCODE is loaded, SHIFT_DR len=32 data=0 -> 37 tck; rsp_data equals the TAP IDCODE constant.
//  Hold rsp_ready=0 for 20 cycles after a RESET response:
//   - rsp_valid stays 1; cmd_ready=0; tck stays 0
//   - on release, the next command is accepted one cycle later
//  Assert sys_rst_n low in the 3rd scan bit of SHIFT_DR len=16:
//   - same cycle: tck=0, tms=1, busy=0
//   - a following SHIFT_DR returns rsp_err=1

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types and TMS sequencing constants for the JTAG host driver.
// TMS vectors are listed LSB-first: bit 0 is driven on the first tck of the sequence.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_IDLE     = 2'd1,
        OP_SHIFT_IR = 2'd2,
        OP_SHIFT_DR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SCAN,
        ST_POST,
        ST_RSP
    } state_e;

    // Five ones force Test-Logic-Reset from any state, the trailing zero parks in Run-Test/Idle
    localparam logic [5:0] RESET_TMS  = 6'b011111;
    localparam int         RESET_LEN  = 6;
    localparam logic [5:0] DR_PRE_TMS = 6'b000001;
    localparam int         DR_PRE_LEN = 3;
    localparam logic [5:0] IR_PRE_TMS = 6'b000011;
    localparam int         IR_PRE_LEN = 4;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [5:0] POST_TMS   = 6'b000001;
    localparam int         POST_LEN   = 2;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHIFT_IR) || (op == OP_SHIFT_DR);
    endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// tck generator: CLK_DIV sys_clk cycles per half-period, low phase first.
// Strobes are asserted in the sys_clk cycle whose closing edge moves tck.
module jtag_host_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          terminal;

    assign terminal = (cnt == CW'(CLK_DIV - 1));
    assign rise_stb = run && terminal && !tck;
    assign fall_stb = run && terminal && tck;

    // Dropping run parks tck low and restarts the phase counter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (terminal) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG probe-side host: runs TAP reset / idle / IR scan / DR scan commands and returns captured tdo.
// Optional JTAG_HOST_TRST_EN adds an active-low trst output released during the RESET command.
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter  int CLK_DIV = 4,
    parameter  int MAX_LEN = 32,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  op_e                cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
`ifdef JTAG_HOST_TRST_EN
    output logic               trst,
`endif
    input  logic               tdo
);
    // Counter must also span the 6-tck reset sequence when MAX_LEN is tiny
    localparam int CW = (LW > 3) ? LW : 3;

    state_e             state, state_nxt;
    op_e                op_q;
    logic [LW-1:0]      len_q;
    logic [CW-1:0]      bit_cnt;
    logic [MAX_LEN-1:0] sreg;
    logic [MAX_LEN:0]   sreg_sh;
    logic [LW-1:0]      shamt;
    logic               tdo_q, err_q, tap_known;
    logic               run, fall_stb, rise_stb;
    logic               accept, cmd_err, last_bit;
    logic [5:0]         pre_tms, pre_sh, post_sh;
    int                 pre_len;

    jtag_host_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .run      (run),
        .tck      (tck),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    assign accept  = cmd_valid && cmd_ready;
    assign cmd_err = (cmd_len > LW'(MAX_LEN))
                  || (is_shift(cmd_op) && (cmd_len == '0))
                  || ((cmd_op != OP_RESET) && !tap_known);

    always_comb begin
        pre_tms = DR_PRE_TMS;
        pre_len = DR_PRE_LEN;
        case (op_q)
            OP_RESET:    begin pre_tms = RESET_TMS;  pre_len = RESET_LEN;  end
            OP_SHIFT_IR: begin pre_tms = IR_PRE_TMS; pre_len = IR_PRE_LEN; end
            default: ;
        endcase
    end

    assign pre_sh  = pre_tms >> bit_cnt;
    assign post_sh = POST_TMS >> bit_cnt;
    assign shamt   = LW'(MAX_LEN) - len_q;
    assign sreg_sh = {tdo_q, sreg};

    always_comb begin
        last_bit = 1'b0;
        case (state)
            ST_PRE:  last_bit = (bit_cnt == CW'(pre_len - 1));
            ST_SCAN: last_bit = (bit_cnt == CW'(len_q) - CW'(1));
            ST_POST: last_bit = (bit_cnt == CW'(POST_LEN - 1));
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) begin
                if (cmd_err)                                         state_nxt = ST_RSP;
                else if (cmd_op == OP_IDLE)                          state_nxt = (cmd_len == '0) ? ST_RSP : ST_SCAN;
                else                                                 state_nxt = ST_PRE;
            end
            ST_PRE:  if (fall_stb && last_bit) state_nxt = (op_q == OP_RESET) ? ST_RSP : ST_SCAN;
            ST_SCAN: if (fall_stb && last_bit) state_nxt = is_shift(op_q) ? ST_POST : ST_RSP;
            ST_POST: if (fall_stb && last_bit) state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready)            state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    // tms/tdi decode from registers that only move on tck falls or at command start
    always_comb begin
        rsp_valid = (state == ST_RSP);
        cmd_ready = (state == ST_IDLE) && !rsp_valid;
        busy      = (state == ST_PRE) || (state == ST_SCAN) || (state == ST_POST);
        run       = busy;
        tms       = 1'b1;
        tdi       = 1'b0;
        case (state)
            ST_PRE:  tms = pre_sh[0];
            ST_SCAN: begin
                tms = is_shift(op_q) && last_bit;
                tdi = is_shift(op_q) && sreg[0];
            end
            ST_POST: tms = post_sh[0];
            default: ;
        endcase
    end

    // tdo lands in tdo_q before the rise and enters the shift register on the following fall,
    // so tdi (sreg[0]) never moves while tck is high
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            op_q      <= OP_RESET;
            len_q     <= '0;
            bit_cnt   <= '0;
            sreg      <= '0;
            tdo_q     <= 1'b0;
            err_q     <= 1'b0;
            rsp_data  <= '0;
            tap_known <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                len_q   <= cmd_len;
                sreg    <= cmd_data;
                err_q   <= cmd_err;
                bit_cnt <= '0;
            end else if (fall_stb) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
                if ((state == ST_SCAN) && is_shift(op_q))
                    sreg <= sreg_sh[MAX_LEN:1];
            end
            if (rise_stb)
                tdo_q <= tdo;
            if ((state != ST_RSP) && (state_nxt == ST_RSP))
                rsp_data <= (state == ST_POST) ? (sreg >> shamt) : '0;
            if ((state == ST_PRE) && (op_q == OP_RESET) && fall_stb && last_bit)
                tap_known <= 1'b1;
        end
    end

    assign rsp_err = err_q;

`ifdef JTAG_HOST_TRST_EN
    // Released on the fall that ends the 5th reset tck; sticky until sys_rst_n
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            trst <= 1'b0;
        else if ((state == ST_PRE) && (op_q == OP_RESET) && fall_stb && (bit_cnt == CW'(4)))
            trst <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver against a behavioural 4-bit-IR TAP with an IDCODE register.
module tb_jtag_host_driver;
    import jtag_host_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam logic [31:0] IDCODE = 32'h4BA0_0477;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               cmd_valid, cmd_ready;
    op_e                cmd_op;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid, rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err, busy;
    logic               tck, tms, tdi;
    logic               tdo = 1'b0;
`ifdef JTAG_HOST_TRST_EN
    logic               trst;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    jtag_host_driver #(.CLK_DIV(4), .MAX_LEN(MAX_LEN)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
`ifdef JTAG_HOST_TRST_EN
        .trst     (trst),
`endif
        .tdo      (tdo)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Behavioural TAP plus a log of tms/tdi seen at every tck rise
    tap_e        tap_st = TLR;
    logic [3:0]  ir     = 4'b1111;
    logic [3:0]  ir_sr  = 4'b0000;
    logic [31:0] dr_sr  = 32'h0;
    int          rise_cnt = 0;
    logic        tms_hist  [0:1023];
    logic        tdi_hist  [0:1023];
    logic        trst_hist [0:1023];

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PA_DR;
            PA_DR:   return m ? EX2_DR : PA_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PA_IR;
            PA_IR:   return m ? EX2_IR : PA_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        tms_hist[rise_cnt] = tms;
        tdi_hist[rise_cnt] = tdi;
`ifdef JTAG_HOST_TRST_EN
        trst_hist[rise_cnt] = trst;
`else
        trst_hist[rise_cnt] = 1'b1;
`endif
        rise_cnt = rise_cnt + 1;
        case (tap_st)
            TLR:     ir = 4'b1111;
            CAP_DR:  dr_sr = (ir == 4'b0001) ? IDCODE : 32'h0;
            SH_DR:   dr_sr = {tdi, dr_sr[31:1]};
            CAP_IR:  ir_sr = 4'b0101;
            SH_IR:   ir_sr = {tdi, ir_sr[3:1]};
            UPD_IR:  ir = ir_sr;
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms);
    end

    always @(negedge tck)
        tdo = (tap_st == SH_DR) ? dr_sr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] seq(input int base, input int n, input bit use_tdi);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = use_tdi ? tdi_hist[base + i] : tms_hist[base + i];
        return v;
    endfunction

    // Leaves the bench in the cycle after acceptance
    task automatic send(input op_e op, input int len, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(posedge sys_clk); #1; n++; end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LW'(len);
        cmd_data  = data;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 2000) begin @(posedge sys_clk); #1; n++; end
        chk("rsp_valid arrives", 64'(rsp_valid), 64'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int base;
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_RESET;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset tck",       64'(tck),       64'd0);
        chk("reset tms",       64'(tms),       64'd1);
        chk("reset tdi",       64'(tdi),       64'd0);
        chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_data",  64'(rsp_data),  64'd0);
        chk("reset rsp_err",   64'(rsp_err),   64'd0);
        chk("reset busy",      64'(busy),      64'd0);
`ifdef JTAG_HOST_TRST_EN
        chk("reset trst",      64'(trst),      64'd0);
`endif
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Scan before the TAP state is known
        base = rise_cnt;
        send(OP_SHIFT_DR, 8, 32'hA5);
        chk("unknown tap rsp_valid", 64'(rsp_valid), 64'd1);
        chk("unknown tap rsp_err",   64'(rsp_err),   64'd1);
        chk("unknown tap rsp_data",  64'(rsp_data),  64'd0);
        ack();
        chk("unknown tap tck rises", 64'(rise_cnt - base), 64'd0);

        // TAP reset
        base = rise_cnt;
        send(OP_RESET, 0, 32'h0);
        chk("reset cmd busy", 64'(busy), 64'd1);
        wait_rsp();
        chk("reset cmd tck rises", 64'(rise_cnt - base), 64'd6);
        chk("reset cmd tms seq",   seq(base, 6, 1'b0),   64'b011111);
        chk("reset cmd rsp_err",   64'(rsp_err),         64'd0);
        chk("reset cmd tap state", 64'(tap_st),          64'(RTI));
`ifdef JTAG_HOST_TRST_EN
        chk("trst low first 5 tck", {59'd0, trst_hist[base+4], trst_hist[base+3], trst_hist[base+2],
                                     trst_hist[base+1], trst_hist[base]}, 64'd0);
        chk("trst high 6th tck",    64'(trst_hist[base+5]), 64'd1);
`endif

        // Response back-pressure
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            chk("hold valid/ready/tck", 64'({rsp_valid, cmd_ready, tck}), 64'b100);
        end
        chk("hold no tck rises", 64'(rise_cnt - base), 64'd6);

        // Release while offering the IR scan; accepted one cycle after the handshake
        base      = rise_cnt;
        cmd_valid = 1'b1;
        cmd_op    = OP_SHIFT_IR;
        cmd_len   = LW'(4);
        cmd_data  = 32'h1;
        rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        rsp_ready = 1'b0;
        chk("post-release cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post-release rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        chk("ir accepted busy", 64'(busy), 64'd1);
        wait_rsp();
        chk("ir tck rises", 64'(rise_cnt - base), 64'd10);
        chk("ir tms seq",   seq(base, 10, 1'b0),  64'b0110000011);
        chk("ir tdi seq",   seq(base, 10, 1'b1),  64'b0000010000);
        chk("ir rsp_data",  64'(rsp_data),        64'h5);
        chk("ir rsp_err",   64'(rsp_err),         64'd0);
        ack();
        chk("ir loaded", 64'(ir), 64'h1);

        // IDCODE read
        base = rise_cnt;
        send(OP_SHIFT_DR, 32, 32'h0);
        wait_rsp();
        chk("idcode tck rises", 64'(rise_cnt - base), 64'd37);
        chk("idcode rsp_data",  64'(rsp_data),        64'(IDCODE));
        chk("idcode tap state", 64'(tap_st),          64'(RTI));
        ack();

        // Idle clocks, zero and non-zero length
        base = rise_cnt;
        send(OP_IDLE, 0, 32'h0);
        chk("idle0 rsp_valid", 64'(rsp_valid), 64'd1);
        chk("idle0 rsp_err",   64'(rsp_err),   64'd0);
        ack();
        chk("idle0 tck rises", 64'(rise_cnt - base), 64'd0);
        base = rise_cnt;
        send(OP_IDLE, 3, 32'h0);
        wait_rsp();
        chk("idle3 tck rises", 64'(rise_cnt - base), 64'd3);
        chk("idle3 tms seq",   seq(base, 3, 1'b0),   64'd0);
        chk("idle3 rsp_err",   64'(rsp_err),         64'd0);
        ack();

        // Over-length and zero-length scans
        base = rise_cnt;
        send(OP_SHIFT_DR, 33, 32'hFFFF_FFFF);
        chk("len33 rsp_valid", 64'(rsp_valid), 64'd1);
        chk("len33 rsp_err",   64'(rsp_err),   64'd1);
        ack();
        send(OP_SHIFT_IR, 0, 32'h0);
        chk("len0 rsp_err",    64'(rsp_err),   64'd1);
        chk("len0 rsp_data",   64'(rsp_data),  64'd0);
        ack();
        chk("errors tck rises", 64'(rise_cnt - base), 64'd0);

        // Reset in the 3rd scan bit of a 16-bit DR scan
        base = rise_cnt;
        send(OP_SHIFT_DR, 16, 32'hBEEF);
        for (int n = 0; n < 500 && (rise_cnt - base) < 6; n++) begin
            @(posedge sys_clk); #1;
        end
        chk("reached 3rd scan bit", 64'(rise_cnt - base), 64'd6);
        sys_rst_n = 1'b0;
        #1;
        chk("midreset tck",       64'(tck),       64'd0);
        chk("midreset tms",       64'(tms),       64'd1);
        chk("midreset busy",      64'(busy),      64'd0);
        chk("midreset cmd_ready", 64'(cmd_ready), 64'd1);
`ifdef JTAG_HOST_TRST_EN
        chk("midreset trst",      64'(trst),      64'd0);
`endif
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        send(OP_SHIFT_DR, 8, 32'h3C);
        chk("after reset rsp_valid", 64'(rsp_valid), 64'd1);
        chk("after reset rsp_err",   64'(rsp_err),   64'd1);
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
